// File: rtl/point_adder_core_pkg.sv
// Shared constants, types and modular add/sub helpers for the Ed25519 point adder.
package point_adder_core_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned PATN_W    = 256;
  localparam int unsigned NUM_BEATS = 12;

  typedef logic [PATN_W-1:0] fe_t;

  localparam fe_t P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam fe_t D = 256'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;

  typedef enum logic [1:0] {StLoad, StCalc, StOut} state_e;

  function automatic fe_t add_mod(fe_t a, fe_t b);
    logic [PATN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[PATN_W-1:0];
  endfunction

  // Wraps modulo 2^256 when a < b; the true result is still below p.
  function automatic fe_t sub_mod(fe_t a, fe_t b);
    return (a >= b) ? a - b : a - b + P;
  endfunction

endpackage

// File: rtl/point_adder_core_mod_mul.sv
// Digit-serial 256x256 multiplier mod 2^255-19, MSB digit of b first (Horner).
module point_adder_core_mod_mul
  import point_adder_core_pkg::*;
#(
  parameter int unsigned DigitW = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [PATN_W-1:0] a_i,
  input  logic [PATN_W-1:0] b_i,
  output logic              done_o,
  output logic [PATN_W-1:0] res_o
);

  localparam int unsigned NumDigits = PATN_W / DigitW;
  localparam int unsigned TW        = PATN_W + DigitW + 1;
  localparam int unsigned CntW      = $clog2(NumDigits + 1);

  logic            busy_q, busy_d, done_q, done_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  fe_t             acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [DigitW-1:0] digit;
  logic [TW-1:0]   prod, fold1;
  fe_t             fold2, step_res;

  always_comb begin
    digit = b_q[PATN_W-1 -: DigitW];
    prod  = TW'({acc_q, {DigitW{1'b0}}}) + TW'(a_q) * TW'(digit);
    // Two folds of 2^255 == 19 leave a value below 2p.
    fold1 = TW'(prod[254:0]) + TW'(prod[TW-1:255]) * TW'(19);
    fold2 = {1'b0, fold1[254:0]} + PATN_W'(fold1[TW-1:255]) * PATN_W'(19);
    step_res = (fold2 >= P) ? fold2 - P : fold2;

    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    if (busy_q) begin
      acc_d = step_res;
      b_d   = b_q << DigitW;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntW'(NumDigits - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign done_o = done_q;
  assign res_o  = acc_q;

endmodule

// File: rtl/point_adder_core.sv
// Ed25519 scalar multiplication: MSB-first double-and-add with unified projective addition.
module point_adder_core
  import point_adder_core_pkg::*;
#(
  parameter int unsigned MulDigitW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_reduce_valid,
  input  logic              i_reduce_ready,
  output logic [PATN_W-1:0] o_reduce_xmp,
  output logic [PATN_W-1:0] o_reduce_ymp,
  output logic [PATN_W-1:0] o_reduce_zmp
);

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d, step_q, step_d;
  logic [7:0]  bit_q, bit_d;
  logic        issue_q, issue_d, dbl_q, dbl_d, ready_q, ready_d, valid_q, valid_d;
  fe_t         k_q, k_d, px_q, px_d, py_q, py_d;
  fe_t         x_q, x_d, y_q, y_d, z_q, z_d;
  fe_t         a_q, a_d, bb_q, bb_d, c_q, c_d, dd_q, dd_d, e_q, e_d, h_q, h_d, t_q, t_d;
  fe_t         f_val, g_val, x2, y2, z2, op_a, op_b, mul_res;
  logic        mul_start, mul_done;

  point_adder_core_mod_mul #(
    .DigitW(MulDigitW)
  ) u_mul (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .start_i(mul_start),
    .a_i    (op_a),
    .b_i    (op_b),
    .done_o (mul_done),
    .res_o  (mul_res)
  );

  always_comb begin
    f_val = sub_mod(bb_q, e_q);
    g_val = add_mod(bb_q, e_q);
    // Second operand is R itself while doubling, P = (x : y : 1) while adding.
    x2 = dbl_q ? x_q : px_q;
    y2 = dbl_q ? y_q : py_q;
    z2 = dbl_q ? z_q : fe_t'(1);
    case (step_q)
      4'd0:    begin op_a = z_q;  op_b = z2;   end
      4'd1:    begin op_a = a_q;  op_b = a_q;  end
      4'd2:    begin op_a = x_q;  op_b = x2;   end
      4'd3:    begin op_a = y_q;  op_b = y2;   end
      4'd4:    begin op_a = c_q;  op_b = dd_q; end
      4'd5:    begin op_a = D;    op_b = e_q;  end
      4'd6:    begin op_a = add_mod(x_q, y_q); op_b = add_mod(x2, y2); end
      4'd7:    begin op_a = a_q;  op_b = f_val; end
      4'd8:    begin op_a = t_q;  op_b = sub_mod(sub_mod(h_q, c_q), dd_q); end
      4'd9:    begin op_a = a_q;  op_b = g_val; end
      4'd10:   begin op_a = t_q;  op_b = add_mod(dd_q, c_q); end
      default: begin op_a = f_val; op_b = g_val; end
    endcase
    mul_start = (state_q == StCalc) && issue_q;

    state_d = state_q; beat_d = beat_q; step_d = step_q; bit_d = bit_q;
    issue_d = issue_q; dbl_d = dbl_q;
    k_d = k_q; px_d = px_q; py_d = py_q; x_d = x_q; y_d = y_q; z_d = z_q;
    a_d = a_q; bb_d = bb_q; c_d = c_q; dd_d = dd_q; e_d = e_q; h_d = h_q; t_d = t_q;

    case (state_q)
      StLoad: begin
        if (i_in_valid && ready_q) begin
          {k_d, px_d, py_d} = {k_q[191:0], px_q, py_q, i_in_data};
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'(NUM_BEATS - 1)) begin
            beat_d  = '0;
            state_d = StCalc;
            x_d = '0; y_d = fe_t'(1); z_d = fe_t'(1);
            bit_d = 8'd255; dbl_d = 1'b1; step_d = '0; issue_d = 1'b1;
          end
        end
      end
      StCalc: begin
        if (mul_start) issue_d = 1'b0;
        if (mul_done) begin
          case (step_q)
            4'd0:         a_d  = mul_res;
            4'd1:         bb_d = mul_res;
            4'd2:         c_d  = mul_res;
            4'd3:         dd_d = mul_res;
            4'd4, 4'd5:   e_d  = mul_res;
            4'd6:         h_d  = mul_res;
            4'd7, 4'd9:   t_d  = mul_res;
            4'd8:         x_d  = mul_res;
            4'd10:        y_d  = mul_res;
            default:      z_d  = mul_res;
          endcase
          if (step_q != 4'd11) begin
            step_d = step_q + 4'd1; issue_d = 1'b1;
          end else if (dbl_q && k_q[bit_q]) begin
            dbl_d = 1'b0; step_d = '0; issue_d = 1'b1;
          end else if (bit_q == 8'd0) begin
            state_d = StOut;
          end else begin
            bit_d = bit_q - 8'd1; dbl_d = 1'b1; step_d = '0; issue_d = 1'b1;
          end
        end
      end
      default: begin
        if (i_reduce_ready) state_d = StLoad;
      end
    endcase

    ready_d = (state_d == StLoad);
    valid_d = (state_d == StOut);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StLoad; beat_q <= '0; step_q <= '0; bit_q <= '0;
      issue_q <= 1'b0; dbl_q <= 1'b0; ready_q <= 1'b0; valid_q <= 1'b0;
      k_q <= '0; px_q <= '0; py_q <= '0; x_q <= '0; y_q <= '0; z_q <= '0;
      a_q <= '0; bb_q <= '0; c_q <= '0; dd_q <= '0; e_q <= '0; h_q <= '0; t_q <= '0;
    end else begin
      state_q <= state_d; beat_q <= beat_d; step_q <= step_d; bit_q <= bit_d;
      issue_q <= issue_d; dbl_q <= dbl_d; ready_q <= ready_d; valid_q <= valid_d;
      k_q <= k_d; px_q <= px_d; py_q <= py_d; x_q <= x_d; y_q <= y_d; z_q <= z_d;
      a_q <= a_d; bb_q <= bb_d; c_q <= c_d; dd_q <= dd_d; e_q <= e_d; h_q <= h_d; t_q <= t_d;
    end
  end

  assign o_in_ready     = ready_q;
  assign o_reduce_valid = valid_q;
  assign o_reduce_xmp   = x_q;
  assign o_reduce_ymp   = y_q;
  assign o_reduce_zmp   = z_q;

endmodule

// File: tb/tb_point_adder_core.sv
// Directed/random bench for point_adder_core against projective and affine reference models.
module tb_point_adder_core;

  localparam logic [255:0] PM = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] DM = 256'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;
  localparam logic [255:0] BX = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
  localparam logic [255:0] BY = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
  localparam int Budget = 40000;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] z;
  } pt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] ox, oy, oz;
  int           checks = 0;
  int           errors = 0;

  point_adder_core #(
    .MulDigitW(256)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
    .o_reduce_valid(out_valid),
    .i_reduce_ready(out_ready),
    .o_reduce_xmp  (ox),
    .o_reduce_ymp  (oy),
    .o_reduce_zmp  (oz)
  );

  always #5 clk = ~clk;

  // ---------------- field / curve reference model ----------------
  function automatic logic [255:0] fmul(logic [255:0] a, logic [255:0] b);
    logic [511:0] w;
    w = {256'd0, a} * {256'd0, b};
    w = w % {256'd0, PM};
    return w[255:0];
  endfunction

  function automatic logic [255:0] fadd(logic [255:0] a, logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, PM};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(logic [255:0] a, logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, PM} - {1'b0, b}) % {1'b0, PM};
    return s[255:0];
  endfunction

  function automatic logic [255:0] finv(logic [255:0] a);
    logic [255:0] r, e;
    r = 256'd1;
    e = PM - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  function automatic pt_t padd(pt_t r, pt_t q);
    logic [255:0] a, b, c, d, e, f, g;
    pt_t o;
    a = fmul(r.z, q.z);
    b = fmul(a, a);
    c = fmul(r.x, q.x);
    d = fmul(r.y, q.y);
    e = fmul(DM, fmul(c, d));
    f = fsub(b, e);
    g = fadd(b, e);
    o.x = fmul(fmul(a, f), fsub(fsub(fmul(fadd(r.x, r.y), fadd(q.x, q.y)), c), d));
    o.y = fmul(fmul(a, g), fadd(d, c));
    o.z = fmul(f, g);
    return o;
  endfunction

  function automatic pt_t pmul(logic [255:0] k, logic [255:0] x, logic [255:0] y);
    pt_t r, p;
    r.x = 256'd0; r.y = 256'd1; r.z = 256'd1;
    p.x = x;      p.y = y;      p.z = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = padd(r, r);
      if (k[i]) r = padd(r, p);
    end
    return r;
  endfunction

  function automatic pt_t aadd(pt_t p1, pt_t p2);
    logic [255:0] t;
    pt_t o;
    t = fmul(DM, fmul(fmul(p1.x, p2.x), fmul(p1.y, p2.y)));
    o.x = fmul(fadd(fmul(p1.x, p2.y), fmul(p1.y, p2.x)), finv(fadd(256'd1, t)));
    o.y = fmul(fadd(fmul(p1.y, p2.y), fmul(p1.x, p2.x)), finv(fsub(256'd1, t)));
    o.z = 256'd1;
    return o;
  endfunction

  // Affine double-and-add; doubling the neutral element is skipped as it is a no-op.
  function automatic pt_t amul(logic [255:0] k, logic [255:0] x, logic [255:0] y);
    pt_t r, p;
    r.x = 256'd0; r.y = 256'd1; r.z = 256'd1;
    p.x = x;      p.y = y;      p.z = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      if (!(r.x == 256'd0 && r.y == 256'd1)) r = aadd(r, r);
      if (k[i]) r = aadd(r, p);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y,
                          input bit gaps);
    logic [767:0] w;
    int g;
    w = {k, x, y};
    chk("in_ready_load", {255'd0, in_ready}, 256'd1);
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = {$urandom, $urandom};
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = w[767-64*i -: 64];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("in_ready_drop", {255'd0, in_ready}, 256'd0);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=valid_low_after_%0d expected=valid_high", tag, n);
    end
    if (out_valid !== 1'b1) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic chk_point(input string tag, input pt_t exp);
    chk({tag, "_x"}, ox, exp.x);
    chk({tag, "_y"}, oy, exp.y);
    chk({tag, "_z"}, oz, exp.z);
  endtask

  task automatic chk_affine(input string tag, input pt_t exp);
    logic [255:0] zi;
    zi = finv(oz);
    chk({tag, "_ax"}, fmul(ox, zi), exp.x);
    chk({tag, "_ay"}, fmul(oy, zi), exp.y);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_hs", {255'd0, out_valid}, 256'd0);
    chk("in_ready_after_hs", {255'd0, in_ready}, 256'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pt_t          ident, base1, expp, expa;
    logic [255:0] rk, rx, ry;

    ident.x = 256'd0; ident.y = 256'd1; ident.z = 256'd1;
    base1.x = BX;     base1.y = BY;     base1.z = 256'd1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_x", ox, 256'd0);
    chk("rst_y", oy, 256'd0);
    chk("rst_z", oz, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_post_rst", {255'd0, in_ready}, 256'd1);

    // k = 1 on the base point with random valid gaps
    send_job(256'd1, BX, BY, 1'b1);
    wait_result("k1");
    chk_point("k1", base1);
    chk_point("k1_model", pmul(256'd1, BX, BY));
    handshake();

    // k = 0 on a random point, result held while downstream stalls
    rx = rand256() % PM;
    ry = rand256() % PM;
    send_job(256'd0, rx, ry, 1'b0);
    wait_result("k0");
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", {255'd0, out_valid}, 256'd1);
      chk_point("stall_k0", ident);
      @(negedge clk);
    end
    handshake();

    // k = 2 issued back-to-back after the previous handshake
    send_job(256'd2, BX, BY, 1'b0);
    expp = pmul(256'd2, BX, BY);
    expa = amul(256'd2, BX, BY);
    wait_result("k2");
    chk_point("k2", expp);
    chk_affine("k2", expa);
    handshake();

    // random k; beats offered during CALC must be ignored
    rk = rand256();
    send_job(rk, BX, BY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    expp = pmul(rk, BX, BY);
    expa = amul(rk, BX, BY);
    wait_result("krand");
    chk_point("krand", expp);
    chk_affine("krand", expa);
    handshake();

    // reset in the middle of CALC, then a fresh k = 1 job
    send_job(rand256(), BX, BY, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {255'd0, out_valid}, 256'd0);
    chk("midrst_in_ready", {255'd0, in_ready}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_post_midrst", {255'd0, in_ready}, 256'd1);
    send_job(256'd1, BX, BY, 1'b1);
    wait_result("k1_after_rst");
    chk_point("k1_after_rst", base1);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
